// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the RAM data-port initiator: funct3 codes,
// FSM state encoding, load extension and sub-word store merging.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Sign/zero extension of the addressed low bytes of a little-endian word.
    function automatic logic [31:0] load_extend(input logic [2:0]  funct3,
                                                input logic [31:0] word);
        logic [31:0] res;
        case (funct3)
            F3_B:    res = {{24{word[7]}}, word[7:0]};
            F3_BU:   res = {24'd0, word[7:0]};
            F3_H:    res = {{16{word[15]}}, word[15:0]};
            F3_HU:   res = {16'd0, word[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    // The RAM always writes four bytes, so sub-word stores keep the upper
    // bytes read back from memory.
    function automatic logic [31:0] store_merge(input logic [2:0]  funct3,
                                                input logic [31:0] old_word,
                                                input logic [31:0] wdata);
        logic [31:0] res;
        case (funct3)
            F3_B:    res = {old_word[31:8], wdata[7:0]};
            F3_H:    res = {old_word[31:16], wdata[15:0]};
            default: res = wdata;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Load/store initiator for a byte-addressed RAM data port. One transaction in
// flight; sub-word stores are done as read-modify-write.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for a request, req_ready high
// READ     | mem_addr held, RAM word captured (load result or RMW old data)
// WRITE    | mem_we pulsed for one cycle with mem_wd
// RESP     | response presented, held until resp_ready
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_SIZE = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rd,
    output logic        mem_we,
    output logic [31:0] mem_wd
);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_err;
    logic        f3_bad;
    logic        misalign;
    logic [32:0] end_addr;

    // Request legality: funct3 set, alignment, and range without address wrap.
    always_comb begin
        end_addr = {1'b0, req_addr} + 33'd3;
        case (req_funct3)
            F3_B, F3_H, F3_W: f3_bad = 1'b0;
            F3_BU, F3_HU:     f3_bad = req_we;
            default:          f3_bad = 1'b1;
        endcase
        misalign = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0])
                || ((req_funct3 == F3_W) && (req_addr[1:0] != 2'b00));
        req_err  = f3_bad || misalign || (end_addr >= 33'(MEM_SIZE));
    end

    // Next-state and datapath updates; everything holds by default.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (req_we) wd_d = req_wdata;
                    if (req_err)
                        state_d = ST_RESP;
                    else if (req_we && req_funct3 == F3_W)
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (we_q) begin
                    wd_d    = store_merge(f3_q, mem_rd, wd_q);
                    state_d = ST_WRITE;
                end else begin
                    rdata_d = load_extend(f3_q, mem_rd);
                    state_d = ST_RESP;
                end
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  if (resp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wd_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wd_q    <= wd_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Reset gates the write strobe combinationally so a reset in WRITE
    // never reaches the RAM.
    assign mem_we     = (state_q == ST_WRITE) && !rst;
    assign req_ready  = (state_q == ST_IDLE) && !rst;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_addr   = addr_q;
    assign mem_wd     = wd_q;

endmodule
